// File: rtl/risc_pkg.sv
// Shared definitions for the load/store path: default widths and the request opcode encoding.
package risc_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 16;
   localparam int MEM_AWIDTH = 3;

   typedef enum logic {
      OP_LD = 1'b0,
      OP_ST = 1'b1
   } req_op_e;

endpackage : risc_pkg

// File: rtl/lsu_store_fifo.sv
// In-order store buffer: circular entry storage with head/tail/count, plus a per-slot view
// of valid/addr/data so the parent can run its forwarding comparator across all live entries.
module lsu_store_fifo #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 16,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [ADDR_W-1:0]             push_addr,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output logic [PTR_W-1:0]              head_ptr,
   output logic [ADDR_W-1:0]             head_addr,
   output logic [DATA_W-1:0]             head_data,
   output logic [DEPTH-1:0]              entry_valid,
   output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
   output logic [DEPTH-1:0][DATA_W-1:0]  entry_data
);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [PTR_W:0]    count_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: entry storage has no reset; an entry is only meaningful while count covers it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_q[tail_q] <= push_addr;
         data_q[tail_q] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
         count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      logic [PTR_W-1:0] offs;
      entry_valid = '0;
      offs        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs           = PTR_W'(i) - head_q;
         entry_valid[i] = ({1'b0, offs} < count_q);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_view
      assign entry_addr[g] = addr_q[g];
      assign entry_data[g] = data_q[g];
   end

   assign head_ptr  = head_q;
   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];

endmodule : lsu_store_fifo

// File: rtl/lsu_store_buffer.sv
// Load/store unit in front of the single-ported data memory: posts stores to an in-order buffer,
// drains them when no load needs the port, and forwards the youngest aliasing store to loads.
module lsu_store_buffer #(
   parameter int DATA_W     = risc_pkg::DATA_W,
   parameter int ADDR_W     = risc_pkg::ADDR_W,
   parameter int DEPTH      = 4,
   parameter int MEM_AWIDTH = risc_pkg::MEM_AWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              drained,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);
   import risc_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   req_op_e                        op;
   logic                           accept;
   logic                           ld_acc;
   logic                           st_acc;
   logic                           drain;
   logic                           full;
   logic                           empty;
   logic [PTR_W-1:0]               head_ptr;
   logic [ADDR_W-1:0]              head_addr;
   logic [DATA_W-1:0]              head_data;
   logic [DEPTH-1:0]               entry_valid;
   logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr;
   logic [DEPTH-1:0][DATA_W-1:0]   entry_data;
   logic                           fwd_hit;
   logic [DATA_W-1:0]              fwd_data;

   assign op        = req_op_e'(req_we);
   assign req_ready = !full;
   assign accept    = req_valid && req_ready;
   assign ld_acc    = accept && (op == OP_LD);
   assign st_acc    = accept && (op == OP_ST);
   // An accepted load always owns the port; the buffer only drains in load-free cycles.
   assign drain     = !ld_acc && !empty;
   assign drained   = empty;

   lsu_store_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (st_acc),
      .push_addr   (req_addr),
      .push_data   (req_wdata),
      .pop         (drain),
      .full        (full),
      .empty       (empty),
      .head_ptr    (head_ptr),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .entry_valid (entry_valid),
      .entry_addr  (entry_addr),
      .entry_data  (entry_data)
   );

   // Walk oldest to youngest so the last hit, the youngest aliasing store, wins.
   always_comb begin
      logic [PTR_W-1:0] slot;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head_ptr + PTR_W'(k);
         if (entry_valid[slot] &&
             (entry_addr[slot][MEM_AWIDTH-1:0] == req_addr[MEM_AWIDTH-1:0])) begin
            fwd_hit  = 1'b1;
            fwd_data = entry_data[slot];
         end
      end
   end

   always_comb begin
      mem_access_addr = '0;
      mem_write_data  = '0;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      if (ld_acc) begin
         mem_read        = 1'b1;
         mem_access_addr = req_addr;
      end else if (drain) begin
         mem_write_en    = 1'b1;
         mem_access_addr = head_addr;
         mem_write_data  = head_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= ld_acc;
         if (ld_acc) rsp_rdata <= fwd_hit ? fwd_data : mem_read_data;
      end
   end

endmodule : lsu_store_buffer
